// File: rtl/soc_obi_pkg.sv
// Shared types and index-width helpers for the OBI crossbar.
package soc_obi_pkg;

    // Default configuration of the crossbar.
    localparam int unsigned NUM_MST_DEF = 2;
    localparam int unsigned NUM_SLV_DEF = 3;
    localparam int unsigned ADDR_W_DEF  = 32;
    localparam int unsigned DATA_W_DEF  = 32;
    localparam int unsigned MAX_OUT_DEF = 4;

    // Index width for n items; a single item still needs one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned MST_IDX_W = idx_w(NUM_MST_DEF);
    localparam int unsigned SLV_IDX_W = idx_w(NUM_SLV_DEF);
    localparam int unsigned OST_IDX_W = idx_w(MAX_OUT_DEF);

    // Address window owned by one slave: [start_addr, end_addr).
    typedef struct packed {
        logic [ADDR_W_DEF-1:0] start_addr;
        logic [ADDR_W_DEF-1:0] end_addr;
    } addr_rule_t;

    typedef struct packed {
        logic                    req;
        logic                    we;
        logic [ADDR_W_DEF-1:0]   addr;
        logic [DATA_W_DEF/8-1:0] be;
        logic [DATA_W_DEF-1:0]   wdata;
    } obi_req_t;

    typedef struct packed {
        logic                  gnt;
        logic                  rvalid;
        logic                  err;
        logic [DATA_W_DEF-1:0] rdata;
    } obi_rsp_t;

endpackage

// File: rtl/soc_obi_rr_arbiter.sv
// Round-robin arbiter: one-hot grant, pointer moves past the winner on advance.
module soc_obi_rr_arbiter
    import soc_obi_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               advance_i,
    output logic [NUM_REQ-1:0] gnt_o
);

    localparam int unsigned IDX_W = idx_w(NUM_REQ);

    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] win_idx;
    logic [IDX_W-1:0] next_ptr;
    logic             found;
    int unsigned      idx;

    // Search from the pointer upwards (wrapping) for the first requester.
    always_comb begin
        gnt_o   = '0;
        win_idx = '0;
        found   = 1'b0;
        idx     = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = 32'(ptr_q) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!found && req_i[idx[IDX_W-1:0]]) begin
                found                   = 1'b1;
                gnt_o[idx[IDX_W-1:0]]   = 1'b1;
                win_idx                 = idx[IDX_W-1:0];
            end
        end
        next_ptr = (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + IDX_W'(1);
    end

    // Pointer only moves on an accepted transfer.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else if (advance_i && found) begin
            ptr_q <= next_ptr;
        end
    end

endmodule

// File: rtl/soc_obi_xbar.sv
// OBI crossbar: NUM_MST cores to NUM_SLV memories/peripherals, in-order responses.
// Optional SOC_OBI_XBAR_DECERR_EN adds a local error responder for unmapped addresses.
module soc_obi_xbar
    import soc_obi_pkg::*;
#(
    parameter int unsigned NUM_MST         = NUM_MST_DEF,
    parameter int unsigned NUM_SLV         = NUM_SLV_DEF,
    parameter int unsigned ADDR_W          = ADDR_W_DEF,
    parameter int unsigned DATA_W          = DATA_W_DEF,
    parameter int unsigned MAX_OUTSTANDING = MAX_OUT_DEF,
    parameter int unsigned DEFAULT_SLV     = 0
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic [NUM_MST-1:0]                 mst_req_i,
    input  logic [NUM_MST-1:0]                 mst_we_i,
    input  logic [NUM_MST-1:0][ADDR_W-1:0]     mst_addr_i,
    input  logic [NUM_MST-1:0][DATA_W/8-1:0]   mst_be_i,
    input  logic [NUM_MST-1:0][DATA_W-1:0]     mst_wdata_i,
    output logic [NUM_MST-1:0]                 mst_gnt_o,
    output logic [NUM_MST-1:0]                 mst_rvalid_o,
    output logic [NUM_MST-1:0]                 mst_err_o,
    output logic [NUM_MST-1:0][DATA_W-1:0]     mst_rdata_o,
    output logic [NUM_SLV-1:0]                 slv_req_o,
    output logic [NUM_SLV-1:0]                 slv_we_o,
    output logic [NUM_SLV-1:0][ADDR_W-1:0]     slv_addr_o,
    output logic [NUM_SLV-1:0][DATA_W/8-1:0]   slv_be_o,
    output logic [NUM_SLV-1:0][DATA_W-1:0]     slv_wdata_o,
    input  logic [NUM_SLV-1:0]                 slv_gnt_i,
    input  logic [NUM_SLV-1:0]                 slv_rvalid_i,
    input  logic [NUM_SLV-1:0]                 slv_err_i,
    input  logic [NUM_SLV-1:0][DATA_W-1:0]     slv_rdata_i,
    input  logic [NUM_SLV-1:0][ADDR_W-1:0]     rule_start_i,
    input  logic [NUM_SLV-1:0][ADDR_W-1:0]     rule_end_i
);

    localparam int unsigned MST_W = idx_w(NUM_MST);
    localparam int unsigned OST_W = $clog2(MAX_OUTSTANDING);
    localparam int unsigned TGT_W = idx_w(NUM_SLV + 1);
    localparam logic [OST_W:0] CNT_MAX = (OST_W + 1)'(MAX_OUTSTANDING);

`ifdef SOC_OBI_XBAR_DECERR_EN
    localparam int unsigned UNMAPPED_TGT = NUM_SLV;
`else
    localparam int unsigned UNMAPPED_TGT = DEFAULT_SLV;
`endif

    logic [NUM_MST-1:0][TGT_W-1:0]                     tgt;
    logic [NUM_MST-1:0]                                mapped;
    logic [NUM_MST-1:0]                                elig;
    logic [NUM_MST-1:0][OST_W:0]                       cnt_q;
    logic [NUM_MST-1:0][TGT_W-1:0]                     last_q;
    logic [NUM_SLV-1:0][NUM_MST-1:0]                   arb_req;
    logic [NUM_SLV-1:0][NUM_MST-1:0]                   arb_gnt;
    logic [NUM_SLV-1:0][MST_W-1:0]                     win_idx;
    logic [NUM_SLV-1:0]                                push;
    logic [NUM_SLV-1:0]                                pop;
    logic [NUM_SLV-1:0]                                fifo_full;
    logic [NUM_SLV-1:0]                                fifo_empty;
    logic [NUM_SLV-1:0][MST_W-1:0]                     head;
    logic [NUM_SLV-1:0][MAX_OUTSTANDING-1:0][MST_W-1:0] fifo_mem_q;
    logic [NUM_SLV-1:0][OST_W-1:0]                     wptr_q;
    logic [NUM_SLV-1:0][OST_W-1:0]                     rptr_q;
    logic [NUM_SLV-1:0][OST_W:0]                       fcnt_q;
    logic [NUM_MST-1:0]                                derr_gnt;
    logic [NUM_MST-1:0]                                derr_q;

    // Address decode: first (lowest-index) matching window wins.
    always_comb begin
        tgt    = '0;
        mapped = '0;
        for (int unsigned m = 0; m < NUM_MST; m++) begin
            tgt[m] = TGT_W'(UNMAPPED_TGT);
            for (int unsigned k = 0; k < NUM_SLV; k++) begin
                if (!mapped[m] && (mst_addr_i[m] >= rule_start_i[k]) &&
                    (mst_addr_i[m] < rule_end_i[k])) begin
                    mapped[m] = 1'b1;
                    tgt[m]    = TGT_W'(k);
                end
            end
        end
    end

    // A master may issue only below the limit and only to its current target while busy.
    always_comb begin
        elig    = '0;
        arb_req = '0;
        for (int unsigned m = 0; m < NUM_MST; m++) begin
            elig[m] = rst_ni && mst_req_i[m] && (cnt_q[m] != CNT_MAX) &&
                      ((cnt_q[m] == '0) || (last_q[m] == tgt[m]));
            for (int unsigned s = 0; s < NUM_SLV; s++) begin
                arb_req[s][m] = elig[m] && (tgt[m] == TGT_W'(s)) && !fifo_full[s];
            end
        end
    end

    for (genvar s = 0; s < NUM_SLV; s++) begin : g_slv
        soc_obi_rr_arbiter #(
            .NUM_REQ (NUM_MST)
        ) u_arb (
            .clk_i     (clk_i),
            .rst_ni    (rst_ni),
            .req_i     (arb_req[s]),
            .advance_i (push[s]),
            .gnt_o     (arb_gnt[s])
        );

        // A slave must never answer without an accepted request in flight.
        a_no_orphan_rsp: assert property (@(posedge clk_i) disable iff (!rst_ni)
            !(slv_rvalid_i[s] && fifo_empty[s]));
    end

    // Winner's request fields drive each slave port; grant is reflected back.
    always_comb begin
        slv_req_o   = '0;
        slv_we_o    = '0;
        slv_addr_o  = '0;
        slv_be_o    = '0;
        slv_wdata_o = '0;
        win_idx     = '0;
        push        = '0;
        mst_gnt_o   = derr_gnt;
        for (int unsigned s = 0; s < NUM_SLV; s++) begin
            slv_req_o[s] = |arb_req[s];
            push[s]      = slv_req_o[s] && slv_gnt_i[s];
            for (int unsigned m = 0; m < NUM_MST; m++) begin
                if (arb_gnt[s][m]) begin
                    slv_we_o[s]    = mst_we_i[m];
                    slv_addr_o[s]  = mst_addr_i[m];
                    slv_be_o[s]    = mst_be_i[m];
                    slv_wdata_o[s] = mst_wdata_i[m];
                    win_idx[s]     = MST_W'(m);
                    if (slv_gnt_i[s]) begin
                        mst_gnt_o[m] = 1'b1;
                    end
                end
            end
        end
    end

    // Responses go straight to the master recorded at the head of each ID FIFO.
    always_comb begin
        mst_rvalid_o = derr_q;
        mst_err_o    = derr_q;
        mst_rdata_o  = '0;
        pop          = '0;
        head         = '0;
        fifo_full    = '0;
        fifo_empty   = '0;
        for (int unsigned s = 0; s < NUM_SLV; s++) begin
            fifo_full[s]  = (fcnt_q[s] == CNT_MAX);
            fifo_empty[s] = (fcnt_q[s] == '0);
            head[s]       = fifo_mem_q[s][rptr_q[s]];
            pop[s]        = slv_rvalid_i[s] && !fifo_empty[s];
            if (pop[s]) begin
                mst_rvalid_o[head[s]] = 1'b1;
                mst_err_o[head[s]]    = slv_err_i[s];
                mst_rdata_o[head[s]]  = slv_rdata_i[s];
            end
        end
    end

    // Per-slave ID FIFOs tracking which master owns each in-flight transfer.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fifo_mem_q <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            fcnt_q     <= '0;
        end else begin
            for (int unsigned s = 0; s < NUM_SLV; s++) begin
                if (push[s]) begin
                    fifo_mem_q[s][wptr_q[s]] <= win_idx[s];
                    wptr_q[s]                <= wptr_q[s] + OST_W'(1);
                end
                if (pop[s]) begin
                    rptr_q[s] <= rptr_q[s] + OST_W'(1);
                end
                if (push[s] && !pop[s]) begin
                    fcnt_q[s] <= fcnt_q[s] + (OST_W + 1)'(1);
                end else if (!push[s] && pop[s]) begin
                    fcnt_q[s] <= fcnt_q[s] - (OST_W + 1)'(1);
                end
            end
        end
    end

    // Per-master outstanding count and current target.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q  <= '0;
            last_q <= '0;
        end else begin
            for (int unsigned m = 0; m < NUM_MST; m++) begin
                if (mst_gnt_o[m] && !mst_rvalid_o[m]) begin
                    cnt_q[m] <= cnt_q[m] + (OST_W + 1)'(1);
                end else if (!mst_gnt_o[m] && mst_rvalid_o[m] && (cnt_q[m] != '0)) begin
                    cnt_q[m] <= cnt_q[m] - (OST_W + 1)'(1);
                end
                if (mst_gnt_o[m]) begin
                    last_q[m] <= tgt[m];
                end
            end
        end
    end

`ifdef SOC_OBI_XBAR_DECERR_EN
    // Error responder: accept unmapped requests at once, answer one cycle later.
    // The one-cycle latency keeps each master's responses in order without a FIFO.
    always_comb begin
        derr_gnt = '0;
        for (int unsigned m = 0; m < NUM_MST; m++) begin
            derr_gnt[m] = elig[m] && (tgt[m] == TGT_W'(NUM_SLV));
        end
    end

    // Error response pipeline stage.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            derr_q <= '0;
        end else begin
            derr_q <= derr_gnt;
        end
    end
`else
    assign derr_gnt = '0;
    assign derr_q   = '0;
`endif

endmodule
